// File: rtl/ser_pkg.sv
// ser_pkg: shared types and default geometry for the byte-serial stream blocks.
package ser_pkg;
    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    typedef enum logic {IDLE, SEND} ser_state_t;
    typedef logic [DATA_W-1:0] byte_t;
endpackage

// File: rtl/lane_counter.sv
// lane_counter: loadable up-counter that saturates at MAX and flags it as terminal.
module lane_counter #(
    parameter int W   = 2,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign term_o = cnt_q == W'(MAX);
    always_comb cnt_d = load_i ? load_val_i : (en_i && !term_o) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: unpacks a LANES-byte word into a lane-0-first byte stream over valid/ready.
module byte_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W = ser_pkg::DATA_W,
    parameter int LANES  = ser_pkg::LANES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0][DATA_W-1:0] inp,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         final_output,
    output logic [DATA_W-1:0]            outp,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy
);
    localparam int CW = $clog2(LANES);
    ser_state_t state_q, state_d;
    logic [LANES-1:0][DATA_W-1:0] held_q, held_d;
    logic [CW-1:0] cnt;
    logic term, load, beat;
    assign busy      = state_q == SEND;
    assign out_valid = busy;
    assign out_last  = busy && term;
    assign outp      = busy ? held_q[cnt] : '0;
    assign beat      = out_valid && out_ready;
    assign in_ready  = !busy || (beat && out_last);
    assign load      = in_valid && in_ready;
    // Final mode starts the counter on the top lane so only that byte is sent.
    lane_counter #(.W(CW), .MAX(LANES - 1)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .load_val_i(final_output ? CW'(LANES - 1) : '0),
        .en_i      (beat && !out_last),
        .cnt_o     (cnt),
        .term_o    (term)
    );
    always_comb begin
        held_d  = load ? inp : held_q;
        state_d = state_q;
        if (state_q == IDLE) state_d = load ? SEND : IDLE;
        else if (beat && out_last) state_d = load ? SEND : IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed vector table plus reset and loopback sequences.
module tb_byte_serializer;
    logic clk = 0, rst = 1;
    logic [3:0][7:0] inp = '0;
    logic in_valid = 0, final_output = 0, out_ready = 0;
    logic in_ready, out_valid, out_last, busy;
    logic [7:0] outp;
    logic [31:0] sr = '0;
    int checks = 0, errors = 0;

    typedef struct {
        logic iv; logic fo; logic ordy; logic [31:0] w;
        logic ev; logic [7:0] eo; logic el; logic eir;
    } vec_t;
    vec_t tv[$];

    byte_serializer dut (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .in_ready(in_ready),
        .final_output(final_output), .outp(outp), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Byte-accumulating shift register: newest byte enters at the top.
    always_ff @(posedge clk)
        if (out_valid && out_ready) sr <= {outp, sr[31:8]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(logic iv, logic fo, logic ordy, logic [31:0] w,
                               logic ev, logic [7:0] eo, logic el, logic eir);
        vec_t r;
        r.iv = iv; r.fo = fo; r.ordy = ordy; r.w = w;
        r.ev = ev; r.eo = eo; r.el = el; r.eir = eir;
        return r;
    endfunction

    initial begin
        // single word
        tv.push_back(v(1, 0, 1, 32'h44332211, 0, 8'h00, 0, 1));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h11, 0, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h22, 0, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h33, 0, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h44, 1, 1));
        tv.push_back(v(0, 0, 1, 32'h0,        0, 8'h00, 0, 1));
        // back-to-back
        tv.push_back(v(1, 0, 1, 32'h44332211, 0, 8'h00, 0, 1));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h11, 0, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h22, 0, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h33, 0, 0));
        tv.push_back(v(1, 0, 1, 32'hA3A2A1A0, 1, 8'h44, 1, 1));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'hA0, 0, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'hA1, 0, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'hA2, 0, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'hA3, 1, 1));
        tv.push_back(v(0, 0, 1, 32'h0,        0, 8'h00, 0, 1));
        // final mode
        tv.push_back(v(1, 1, 1, 32'h04030201, 0, 8'h00, 0, 1));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h04, 1, 1));
        tv.push_back(v(0, 0, 1, 32'h0,        0, 8'h00, 0, 1));
        // backpressure, including a stall on the last beat
        tv.push_back(v(1, 0, 1, 32'h44332211, 0, 8'h00, 0, 1));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h11, 0, 0));
        tv.push_back(v(0, 0, 0, 32'h0,        1, 8'h22, 0, 0));
        tv.push_back(v(0, 0, 0, 32'h0,        1, 8'h22, 0, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h22, 0, 0));
        tv.push_back(v(0, 0, 0, 32'h0,        1, 8'h33, 0, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h33, 0, 0));
        tv.push_back(v(1, 0, 0, 32'h55555555, 1, 8'h44, 1, 0));
        tv.push_back(v(0, 0, 1, 32'h0,        1, 8'h44, 1, 1));
        tv.push_back(v(0, 0, 1, 32'h0,        0, 8'h00, 0, 1));

        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_outp", outp, 0);
        @(negedge clk);
        rst = 0;

        foreach (tv[i]) begin
            @(negedge clk);
            in_valid = tv[i].iv; final_output = tv[i].fo; out_ready = tv[i].ordy; inp = tv[i].w;
            #1;
            check($sformatf("v%0d_out_valid", i), out_valid, tv[i].ev);
            check($sformatf("v%0d_outp", i), outp, tv[i].eo);
            check($sformatf("v%0d_out_last", i), out_last, tv[i].el);
            check($sformatf("v%0d_in_ready", i), in_ready, tv[i].eir);
            check($sformatf("v%0d_busy", i), busy, tv[i].ev);
        end

        // async reset mid-word
        @(negedge clk);
        in_valid = 1; inp = 32'h88776655; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        check("pre_reset_outp", outp, 8'h66);
        #2 rst = 1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_outp", outp, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("post_reset_idle", out_valid, 0);

        // loopback into the shift register
        begin
            bit done = 0;
            in_valid = 1; inp = 32'hDEADBEEF; out_ready = 1;
            @(negedge clk);
            in_valid = 0;
            for (int k = 0; k < 20 && !done; k++) begin
                #1;
                if (out_valid && out_last) done = 1;
                @(negedge clk);
            end
            check("loopback_done", done, 1);
            check("loopback_word", sr, 32'hDEADBEEF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
